// File: rtl/relu_maxpool_stream.sv
// Captures a full conv feature map, then streams ReLU'd max-pooled words
// row-major over valid/ready, one pooled word per cycle when unstalled.
module relu_maxpool_stream #(
  parameter int double_word_length = 16,
  parameter int output_size        = 24,
  parameter int pool_size          = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  in_valid,
  input  logic [double_word_length*output_size*output_size-1:0] data_in,
  output logic                                                  in_ready,
  output logic [double_word_length-1:0]                         data_out,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic                                                  out_last,
  output logic                                                  overrun
);
  localparam int DW       = double_word_length;
  localparam int POOL_OUT = output_size / pool_size;
  localparam int N_OUT    = POOL_OUT * POOL_OUT;
  localparam int IW       = $clog2(N_OUT);
  localparam int MAP_W    = DW * output_size * output_size;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t           state, next_state;
  logic [MAP_W-1:0] map_q;
  logic [IW-1:0]    idx, pidx;
  logic [DW-1:0]    win_max, win_word, pool_val;
  logic             adv;
  int               pr, pc, base;

  assign in_ready = (state == IDLE);
  // The pool unit always evaluates the word to be loaded at the next edge:
  // idx during CALC, idx+1 when the current word is being accepted in EMIT.
  assign adv  = (state == EMIT) && out_ready && !out_last;
  assign pidx = adv ? idx + 1'b1 : idx;

  always_comb begin
    pr       = int'(pidx) / POOL_OUT;
    pc       = int'(pidx) % POOL_OUT;
    base     = pr * pool_size * output_size + pc * pool_size;
    win_max  = map_q[base*DW +: DW];
    win_word = '0;
    for (int i = 0; i < pool_size; i++) begin
      for (int j = 0; j < pool_size; j++) begin
        win_word = map_q[(base + i*output_size + j)*DW +: DW];
        if ($signed(win_word) > $signed(win_max)) win_max = win_word;
      end
    end
    pool_val = win_max[DW-1] ? '0 : win_max;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = CALC;
      CALC:    next_state = EMIT;
      EMIT:    if (out_ready && out_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Map storage carries no reset; it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) map_q <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overrun <= 1'b1;
      case (state)
        IDLE: if (in_valid) idx <= '0;
        CALC: begin
          data_out  <= pool_val;
          out_valid <= 1'b1;
          out_last  <= (pidx == LAST_IDX);
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= pidx;
              data_out <= pool_val;
              out_last <= (pidx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench: a behavioural pool model fills the expected queue when a
// map is sent; the consumer pops and compares each accepted output word.
module tb_relu_maxpool_stream;
  localparam int DW = 16, OS = 24, PS = 2, PO = 12, NO = 144, NW = OS*OS;

  logic            clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [DW*NW-1:0] data_in = '0;
  logic            in_ready, out_valid, out_last, overrun;
  logic [DW-1:0]   data_out;

  logic signed [DW-1:0] m [NW];
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   got_q[$];
  int              n_checks = 0, n_fail = 0;

  relu_maxpool_stream #(.double_word_length(DW), .output_size(OS), .pool_size(PS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overrun(overrun));

  always #5 clk = ~clk;

  task automatic build_exp();
    logic signed [DW-1:0] mx;
    exp_q.delete();
    for (int k = 0; k < NO; k++) begin
      mx = m[(2*(k/PO))*OS + 2*(k%PO)];
      for (int i = 0; i < PS; i++)
        for (int j = 0; j < PS; j++)
          if (m[(2*(k/PO)+i)*OS + 2*(k%PO)+j] > mx) mx = m[(2*(k/PO)+i)*OS + 2*(k%PO)+j];
      exp_q.push_back((mx < 0) ? 16'd0 : mx);
    end
  endtask

  // Called at a negedge; returns at the negedge where the first word is valid.
  task automatic send_map();
    for (int w = 0; w < NW; w++) data_in[DW*w +: DW] = m[w];
    build_exp();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: in_ready=%b need 1", in_ready); end
    in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL calc_cycle: out_valid=%b in_ready=%b need 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency: out_valid=%b need 1", out_valid); end
  endtask

  task automatic drain(input bit toggle, input int inject_at, input int stop_at,
                       output int nvalid, output int nxfer);
    bit r, stalled = 0, done = 0, injected = 0;
    logic [DW-1:0] held = '0, e;
    int cyc = 0;
    nvalid = 0; nxfer = 0;
    got_q.delete();
    while (!done && cyc < 2000) begin
      if (stop_at >= 0 && nxfer == stop_at) break;
      if (nxfer == inject_at && !injected) begin
        in_valid = 1; data_in = {NW{16'h1234}}; injected = 1;
      end else in_valid = 0;
      if (out_valid) begin
        nvalid++;
        if (stalled) begin
          n_checks++;
          if (data_out !== held) begin n_fail++; $display("FAIL stall_hold: data_out=%0d need %0d", data_out, held); end
        end
        r = !toggle || nvalid[0];
        out_ready = r;
        if (r) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          got_q.push_back(data_out);
          n_checks++;
          if (data_out !== e) begin n_fail++; $display("FAIL word%0d: data_out=%0d need %0d", nxfer, data_out, e); end
          n_checks++;
          if (out_last !== (exp_q.size() == 0)) begin
            n_fail++; $display("FAIL last%0d: out_last=%b need %b", nxfer, out_last, exp_q.size() == 0);
          end
          nxfer++; stalled = 0;
          if (out_last) done = 1;
        end else begin
          stalled = 1; held = data_out;
        end
      end else out_ready = 1;
      cyc++;
      @(negedge clk);
    end
    in_valid = 0;
    if (!done && stop_at < 0) begin
      n_checks++; n_fail++; $display("FAIL drain_timeout: %0d words, need %0d", nxfer, NO);
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b need 1 0 0", tag, in_ready, out_valid, out_last);
    end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    n_checks++;
    if (data_out !== 16'd0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: data_out=%0d overrun=%b need 0 0", data_out, overrun);
    end
    check_idle("reset_idle");
    @(negedge clk);
    check_idle("reset_idle2");
  endtask

  task automatic test_ramp();
    int nv, nx;
    for (int w = 0; w < NW; w++) m[w] = DW'(w);
    send_map();
    drain(0, -1, -1, nv, nx);
    n_checks++;
    if (nx != NO || got_q.size() != NO) begin n_fail++; $display("FAIL ramp_count: got %0d need %0d", nx, NO); end
    else begin
      n_checks++;
      if (got_q[0] !== 16'd25 || got_q[1] !== 16'd27 || got_q[NO-1] !== 16'd575) begin
        n_fail++; $display("FAIL ramp_known: got %0d %0d %0d need 25 27 575", got_q[0], got_q[1], got_q[NO-1]);
      end
    end
    n_checks++;
    if (nv != NO) begin n_fail++; $display("FAIL ramp_cycles: %0d valid cycles need %0d", nv, NO); end
    check_idle("ramp_back_idle");
  endtask

  task automatic test_negative();
    int nv, nx;
    logic [DW-1:0] fills [2] = '{16'hFFF0, 16'h8000};
    foreach (fills[f]) begin
      for (int w = 0; w < NW; w++) m[w] = fills[f];
      send_map();
      drain(0, -1, -1, nv, nx);
      n_checks++;
      if (nx != NO || got_q[NO-1] !== 16'd0) begin
        n_fail++; $display("FAIL neg_fill%0d: %0d words last=%0d need %0d 0", f, nx, got_q[NO-1], NO);
      end
    end
  endtask

  task automatic test_signed_window();
    int nv, nx;
    for (int w = 0; w < NW; w++) m[w] = DW'($urandom_range(0, 2000));
    m[0] = -16'sd5; m[1] = -16'sd3; m[OS] = 16'sd7; m[OS+1] = 16'sd0;
    m[2] = 16'sh7FFF; m[3] = -16'sd1; m[OS+2] = 16'sd0; m[OS+3] = 16'sd1;
    send_map();
    drain(0, -1, -1, nv, nx);
    n_checks++;
    if (got_q.size() < 2 || got_q[0] !== 16'd7 || got_q[1] !== 16'd32767) begin
      n_fail++; $display("FAIL signed_window: got %0d %0d need 7 32767", got_q[0], got_q[1]);
    end
  endtask

  task automatic test_backpressure();
    int nv, nx;
    for (int w = 0; w < NW; w++) m[w] = DW'(w);
    send_map();
    drain(1, -1, -1, nv, nx);
    n_checks++;
    if (nv != 2*NO-1 || nx != NO) begin
      n_fail++; $display("FAIL stall_cycles: valid=%0d words=%0d need %0d %0d", nv, nx, 2*NO-1, NO);
    end
    n_checks++;
    if (got_q.size() == NO && got_q[NO-1] !== 16'd575) begin
      n_fail++; $display("FAIL stall_last: got %0d need 575", got_q[NO-1]);
    end
  endtask

  task automatic test_overrun();
    int nv, nx;
    for (int w = 0; w < NW; w++) m[w] = DW'($urandom_range(0, 16'hFFFF));
    send_map();
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: overrun=%b need 0", overrun); end
    drain(0, 50, -1, nv, nx);
    n_checks++;
    if (nx != NO || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_stream: words=%0d overrun=%b need %0d 1", nx, overrun, NO);
    end
    repeat (3) @(negedge clk);
    check_idle("overrun_map_ignored");
    for (int w = 0; w < NW; w++) m[w] = DW'($urandom_range(0, 16'hFFFF));
    send_map();
    drain(0, -1, -1, nv, nx);
    n_checks++;
    if (nx != NO || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: words=%0d overrun=%b need %0d 1", nx, overrun, NO);
    end
  endtask

  task automatic test_reset_midstream();
    int nv, nx;
    for (int w = 0; w < NW; w++) m[w] = DW'($urandom_range(0, 16'hFFFF));
    send_map();
    drain(0, -1, 70, nv, nx);
    rst = 1; out_ready = 0;
    @(posedge clk);
    @(negedge clk) rst = 0;
    check_idle("midreset_idle");
    n_checks++;
    if (overrun !== 1'b0 || data_out !== 16'd0) begin
      n_fail++; $display("FAIL midreset_regs: overrun=%b data_out=%0d need 0 0", overrun, data_out);
    end
    for (int w = 0; w < NW; w++) m[w] = DW'(w);
    send_map();
    drain(0, -1, -1, nv, nx);
    n_checks++;
    if (nx != NO || got_q[0] !== 16'd25) begin
      n_fail++; $display("FAIL midreset_fresh: words=%0d first=%0d need %0d 25", nx, got_q[0], NO);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_signed_window();
    test_backpressure();
    test_overrun();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
